// File: rtl/btb_if.sv
// Fetch-side lookup, resolve-side training and statistics bundle for the branch target buffer.
// master = pipeline (IF + resolver), slave = the BTB itself.
interface btb_if #(
    parameter int ADDR_W = 16,
    parameter int STAT_W = 16
);
    logic              lookup_valid;
    logic [ADDR_W-1:0] lookup_pc;
    logic              pred_hit;
    logic              pred_taken;
    logic [ADDR_W-1:0] pred_target;
    logic              upd_valid;
    logic [ADDR_W-1:0] upd_pc;
    logic              upd_taken;
    logic [ADDR_W-1:0] upd_target;
    logic              upd_mispredict;
    logic              bp_clear;
    logic [STAT_W-1:0] stat_hits;
    logic [STAT_W-1:0] stat_mispred;

    modport master (
        output lookup_valid, lookup_pc,
        output upd_valid, upd_pc, upd_taken, upd_target, upd_mispredict, bp_clear,
        input  pred_hit, pred_taken, pred_target,
        input  stat_hits, stat_mispred
    );

    modport slave (
        input  lookup_valid, lookup_pc,
        input  upd_valid, upd_pc, upd_taken, upd_target, upd_mispredict, bp_clear,
        output pred_hit, pred_taken, pred_target,
        output stat_hits, stat_mispred
    );
endinterface

// File: rtl/branch_target_buffer.sv
// Direct-mapped branch target buffer with 2-bit saturating direction counters.
// Lookup is combinational from registered state; training takes effect on the next edge.
module branch_target_buffer #(
    parameter int ADDR_W  = 16,
    parameter int INDEX_W = 4,
    parameter int STAT_W  = 16
) (
    input  logic CLK,
    input  logic RST,
    btb_if.slave bus
);
    localparam int ENTRIES = 2 ** INDEX_W;
    localparam int TAG_W   = ADDR_W - INDEX_W;

    logic [ENTRIES-1:0]      r_valid;
    logic [ENTRIES-1:0]      w_valid_next;
    logic [ENTRIES-1:0][1:0] r_ctr;
    logic [ENTRIES-1:0][1:0] w_ctr_next;
    logic [TAG_W-1:0]        r_tag    [ENTRIES];
    logic [ADDR_W-1:0]       r_target [ENTRIES];
    logic [STAT_W-1:0]       r_stat_hits;
    logic [STAT_W-1:0]       r_stat_mispred;

    logic [INDEX_W-1:0] w_lk_idx;
    logic [TAG_W-1:0]   w_lk_tag;
    logic               w_lk_hit;
    logic               w_lk_taken;
    logic [ADDR_W-1:0]  w_lk_seq;

    logic [INDEX_W-1:0] w_upd_idx;
    logic [TAG_W-1:0]   w_upd_tag;
    logic               w_upd_hit;
    logic               w_upd_cmd;
    logic               w_upd_wr;
    logic [1:0]         w_upd_ctr;
    logic [1:0]         w_ctr_trained;

    // Lookup path
    assign w_lk_idx   = bus.lookup_pc[INDEX_W-1:0];
    assign w_lk_tag   = bus.lookup_pc[ADDR_W-1:INDEX_W];
    assign w_lk_hit   = r_valid[w_lk_idx] && (r_tag[w_lk_idx] == w_lk_tag);
    assign w_lk_taken = w_lk_hit && r_ctr[w_lk_idx][1];
    assign w_lk_seq   = bus.lookup_pc + ADDR_W'(1);

    assign bus.pred_hit    = w_lk_hit;
    assign bus.pred_taken  = w_lk_taken;
    assign bus.pred_target = w_lk_taken ? r_target[w_lk_idx] : w_lk_seq;

    // Training path; a concurrent clear drops the update entirely
    assign w_upd_idx = bus.upd_pc[INDEX_W-1:0];
    assign w_upd_tag = bus.upd_pc[ADDR_W-1:INDEX_W];
    assign w_upd_hit = r_valid[w_upd_idx] && (r_tag[w_upd_idx] == w_upd_tag);
    assign w_upd_cmd = bus.upd_valid && !bus.bp_clear;
    assign w_upd_wr  = w_upd_cmd && bus.upd_taken;
    assign w_upd_ctr = r_ctr[w_upd_idx];

    always_comb begin
        w_ctr_trained = w_upd_ctr;
        if (bus.upd_taken) begin
            if (w_upd_ctr != 2'b11) w_ctr_trained = w_upd_ctr + 2'b01;
        end else begin
            if (w_upd_ctr != 2'b00) w_ctr_trained = w_upd_ctr - 2'b01;
        end
    end

    generate
        for (genvar gi = 0; gi < ENTRIES; gi++) begin : g_entry
            localparam logic [INDEX_W-1:0] LP_IDX = INDEX_W'(gi);
            logic w_sel;

            assign w_sel = w_upd_cmd && (w_upd_idx == LP_IDX);

            // Taken miss allocates weakly-taken; not-taken miss leaves the entry alone
            assign w_valid_next[gi] = bus.bp_clear ? 1'b0 :
                                      (w_sel && bus.upd_taken) ? 1'b1 : r_valid[gi];
            assign w_ctr_next[gi]   = !w_sel          ? r_ctr[gi]     :
                                      w_upd_hit       ? w_ctr_trained :
                                      bus.upd_taken   ? 2'b10         : r_ctr[gi];
        end
    endgenerate

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_valid <= '0;
            r_ctr   <= '0;
        end else begin
            r_valid <= w_valid_next;
            r_ctr   <= w_ctr_next;
        end
    end

    // Tag/target storage carries no reset; validity is owned by r_valid
    always_ff @(posedge CLK) begin
        if (!RST && w_upd_wr) begin
            r_tag[w_upd_idx]    <= w_upd_tag;
            r_target[w_upd_idx] <= bus.upd_target;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_stat_hits    <= '0;
            r_stat_mispred <= '0;
        end else begin
            if (bus.lookup_valid && w_lk_hit && (r_stat_hits != '1))
                r_stat_hits <= r_stat_hits + STAT_W'(1);
            if (bus.upd_valid && bus.upd_mispredict && (r_stat_mispred != '1))
                r_stat_mispred <= r_stat_mispred + STAT_W'(1);
        end
    end

    assign bus.stat_hits    = r_stat_hits;
    assign bus.stat_mispred = r_stat_mispred;
endmodule

// File: tb/tb_branch_target_buffer.sv
// Directed bench for branch_target_buffer: expected predictions go through a scoreboard queue,
// statistics are tracked by a small saturating model.
module tb_branch_target_buffer;
    localparam int ADDR_W  = 16;
    localparam int INDEX_W = 4;
    localparam int STAT_W  = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    btb_if #(.ADDR_W(ADDR_W), .STAT_W(STAT_W)) bus ();

    branch_target_buffer #(.ADDR_W(ADDR_W), .INDEX_W(INDEX_W), .STAT_W(STAT_W)) dut (
        .CLK (clk),
        .RST (rst),
        .bus (bus)
    );

    typedef struct {
        string             tag;
        logic              hit;
        logic              taken;
        logic [ADDR_W-1:0] tgt;
    } exp_t;

    exp_t              sb_q[$];
    int                n_assert = 0;
    int                n_fail   = 0;
    logic [STAT_W-1:0] m_hits   = '0;
    logic [STAT_W-1:0] m_mis    = '0;
    bit                m_known  = 1'b0;
    bit                m_ehit   = 1'b0;

    task automatic chk(input string tag, input logic [ADDR_W-1:0] obs, input logic [ADDR_W-1:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Compare at the falling edge, then advance the model across the rising edge
    task automatic cyc();
        exp_t e;
        @(negedge clk);
        if (m_known) begin
            chk("stat_hits", ADDR_W'(bus.stat_hits), ADDR_W'(m_hits));
            chk("stat_mispred", ADDR_W'(bus.stat_mispred), ADDR_W'(m_mis));
        end
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            chk({e.tag, ".hit"}, ADDR_W'(bus.pred_hit), ADDR_W'(e.hit));
            chk({e.tag, ".taken"}, ADDR_W'(bus.pred_taken), ADDR_W'(e.taken));
            chk({e.tag, ".target"}, bus.pred_target, e.tgt);
            $display("txn %-18s pc=%h hit=%0b taken=%0b target=%h", e.tag, bus.lookup_pc,
                     bus.pred_hit, bus.pred_taken, bus.pred_target);
        end
        if (rst) begin
            m_hits = '0;
            m_mis  = '0;
        end else begin
            if (bus.lookup_valid && m_ehit && m_hits != '1) m_hits = m_hits + 1'b1;
            if (bus.upd_valid && bus.upd_mispredict && m_mis != '1) m_mis = m_mis + 1'b1;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic step(input string tag, input logic lv, input logic [ADDR_W-1:0] lpc,
                        input logic uv, input logic [ADDR_W-1:0] upc, input logic ut,
                        input logic [ADDR_W-1:0] utgt, input logic um, input logic clr,
                        input logic eh, input logic et, input logic [ADDR_W-1:0] etgt);
        exp_t e;
        bus.lookup_valid   = lv;
        bus.lookup_pc      = lpc;
        bus.upd_valid      = uv;
        bus.upd_pc         = upc;
        bus.upd_taken      = ut;
        bus.upd_target     = utgt;
        bus.upd_mispredict = um;
        bus.bp_clear       = clr;
        e.tag   = tag;
        e.hit   = eh;
        e.taken = et;
        e.tgt   = etgt;
        sb_q.push_back(e);
        m_ehit = eh;
        cyc();
    endtask

    task automatic reset_cycle(input logic [ADDR_W-1:0] upc);
        rst                = 1'b1;
        bus.lookup_valid   = 1'b0;
        bus.lookup_pc      = '0;
        bus.upd_valid      = 1'b1;
        bus.upd_pc         = upc;
        bus.upd_taken      = 1'b1;
        bus.upd_target     = 16'h0ABC;
        bus.upd_mispredict = 1'b1;
        bus.bp_clear       = 1'b1;
        m_ehit             = 1'b0;
        cyc();
        m_known          = 1'b1;
        rst              = 1'b0;
        bus.upd_valid    = 1'b0;
        bus.bp_clear     = 1'b0;
    endtask

    initial begin
        bus.lookup_valid = 1'b0; bus.lookup_pc = '0; bus.upd_valid = 1'b0; bus.upd_pc = '0;
        bus.upd_taken = 1'b0; bus.upd_target = '0; bus.upd_mispredict = 1'b0; bus.bp_clear = 1'b0;
        @(posedge clk); #1;
        reset_cycle(16'h0010);
        reset_cycle(16'h0010);

        step("t1_reset_miss",   1, 16'h0010, 0, 16'h0000, 0, 16'h0000, 0, 0, 0, 0, 16'h0011);
        step("t2_same_cycle",   1, 16'h0010, 1, 16'h0010, 1, 16'h0040, 1, 0, 0, 0, 16'h0011);
        step("t2_alloc_hit",    1, 16'h0010, 0, 16'h0000, 0, 16'h0000, 0, 0, 1, 1, 16'h0040);
        step("t3_nt1",          1, 16'h0010, 1, 16'h0010, 0, 16'h0000, 1, 0, 1, 1, 16'h0040);
        step("t3_nt2",          0, 16'h0010, 1, 16'h0010, 0, 16'h0000, 0, 0, 1, 0, 16'h0011);
        step("t3_strong_nt",    1, 16'h0010, 0, 16'h0000, 0, 16'h0000, 0, 0, 1, 0, 16'h0011);
        step("t3_t1",           1, 16'h0010, 1, 16'h0010, 1, 16'h0040, 0, 0, 1, 0, 16'h0011);
        step("t3_t2",           0, 16'h0010, 1, 16'h0010, 1, 16'h0040, 0, 0, 1, 0, 16'h0011);
        step("t3_t3",           1, 16'h0010, 1, 16'h0010, 1, 16'h0040, 0, 0, 1, 1, 16'h0040);
        step("t3_t4",           1, 16'h0010, 1, 16'h0010, 1, 16'h0040, 0, 0, 1, 1, 16'h0040);
        step("t3_sat_nt",       1, 16'h0010, 1, 16'h0010, 0, 16'h0000, 1, 0, 1, 1, 16'h0040);
        step("t3_after_nt",     1, 16'h0010, 0, 16'h0000, 0, 16'h0000, 0, 0, 1, 1, 16'h0040);

        step("t4_alias_alloc",  1, 16'h0010, 1, 16'h0020, 1, 16'h0100, 1, 0, 1, 1, 16'h0040);
        step("t4_alias_hit",    1, 16'h0020, 0, 16'h0000, 0, 16'h0000, 0, 0, 1, 1, 16'h0100);
        step("t4_old_miss",     1, 16'h0010, 0, 16'h0000, 0, 16'h0000, 0, 0, 0, 0, 16'h0011);
        step("t4_nt_miss",      1, 16'h0030, 1, 16'h0030, 0, 16'h0777, 0, 0, 0, 0, 16'h0031);
        step("t4_no_alloc",     1, 16'h0030, 0, 16'h0000, 0, 16'h0000, 0, 0, 0, 0, 16'h0031);
        step("t4_survivor",     1, 16'h0020, 0, 16'h0000, 0, 16'h0000, 0, 0, 1, 1, 16'h0100);
        step("t4_alloc_idx3",   0, 16'h0123, 1, 16'h0123, 1, 16'h0456, 0, 0, 0, 0, 16'h0124);
        step("t4_idx3_hit",     1, 16'h0123, 0, 16'h0000, 0, 16'h0000, 0, 0, 1, 1, 16'h0456);
        step("t4_idx0_intact",  1, 16'h0020, 0, 16'h0000, 0, 16'h0000, 0, 0, 1, 1, 16'h0100);
        step("t4_alloc_ffff",   1, 16'hFFFF, 1, 16'hFFFF, 1, 16'h1234, 0, 0, 0, 0, 16'h0000);
        step("t4_ffff_hit",     1, 16'hFFFF, 0, 16'h0000, 0, 16'h0000, 0, 0, 1, 1, 16'h1234);
        step("t4_retarget",     1, 16'h0020, 1, 16'h0020, 1, 16'h0300, 0, 0, 1, 1, 16'h0100);
        step("t4_retarget_hit", 1, 16'h0020, 1, 16'h0020, 0, 16'h0999, 0, 0, 1, 1, 16'h0300);
        step("t4_nt_keeps_tgt", 1, 16'h0020, 0, 16'h0000, 0, 16'h0000, 0, 0, 1, 1, 16'h0300);

        step("t5_clear",        1, 16'h0020, 1, 16'h0050, 1, 16'h0200, 1, 1, 1, 1, 16'h0300);
        step("t5_miss_0020",    1, 16'h0020, 0, 16'h0000, 0, 16'h0000, 0, 0, 0, 0, 16'h0021);
        step("t5_miss_0123",    1, 16'h0123, 0, 16'h0000, 0, 16'h0000, 0, 0, 0, 0, 16'h0124);
        step("t5_miss_0050",    1, 16'h0050, 0, 16'h0000, 0, 16'h0000, 0, 0, 0, 0, 16'h0051);
        step("t5_miss_ffff",    1, 16'hFFFF, 0, 16'h0000, 0, 16'h0000, 0, 0, 0, 0, 16'h0000);

        reset_cycle(16'h0020);
        chk("t6_hits_zero", ADDR_W'(bus.stat_hits), 16'd0);
        step("t6_post_rst",     1, 16'h0020, 0, 16'h0000, 0, 16'h0000, 0, 0, 0, 0, 16'h0021);
        step("t6_alloc",        0, 16'h0020, 1, 16'h0020, 1, 16'h0100, 0, 0, 0, 0, 16'h0021);
        for (int i = 0; i < 20; i++)
            step("t6_hit",      1, 16'h0020, 0, 16'h0000, 0, 16'h0000, 0, 0, 1, 1, 16'h0100);
        chk("t6_hits_sat", ADDR_W'(bus.stat_hits), 16'd15);
        for (int i = 0; i < 3; i++)
            step("t6_mispred",  0, 16'h0070, 1, 16'h0070, 0, 16'h0000, 1, 0, 0, 0, 16'h0071);
        chk("t6_mispred_cnt", ADDR_W'(bus.stat_mispred), 16'd3);
        reset_cycle(16'h0020);
        chk("t6_rst_hits", ADDR_W'(bus.stat_hits), 16'd0);
        chk("t6_rst_mispred", ADDR_W'(bus.stat_mispred), 16'd0);
        step("t6_rst_miss",     1, 16'h0020, 0, 16'h0000, 0, 16'h0000, 0, 0, 0, 0, 16'h0021);
        step("t6_rst_miss_ff",  1, 16'hFFFF, 0, 16'h0000, 0, 16'h0000, 0, 0, 0, 0, 16'h0000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
